// File: rtl/fetcher_pkg.sv
// Shared widths, FSM encodings and instruction-queue line layout for the fetch stage.
// No logic of its own; no latency.
// No flow control of its own.
package fetcher_pkg;

    localparam int INS_WIDTH      = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int IQ_LINE_LENGTH = ADDR_WIDTH + INS_WIDTH;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_WAIT = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_t;

    // One queue entry: the instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INS_WIDTH-1:0]  ins;
    } iq_line_t;

    // Static predict-not-taken: the next sequential word; wraps at 32 bits.
    function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
        return pc + ADDR_WIDTH'(4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, ins} lines; flush empties it and overrides a same-cycle push.
// Pushed data is visible at the head the cycle after the push.
// No internal backpressure: the caller reserves a slot before issuing, so push never meets full.
module fetch_queue #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 64
) (
    input  logic                  core_clk,
    input  logic                  arst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_dat,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;

    // Pointer and occupancy tracking; flush collapses head onto tail.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge core_clk) begin
        if (push && !flush) mem[tail] <= push_dat;
    end

    assign head_dat = mem[head];
    assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/fetcher.sv
// Instruction fetch: one-outstanding icache requests, queue of {pc, ins}, head presented to decode.
// Response pushed on the valid edge, visible to decode the next cycle; request issue 1 cycle after a free slot.
// Decode delivery stalls on rob_full/rs_full/rdy_in/jump; requests stop when queue slots are all reserved.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int                    IQ_WIDTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_full,
    input  logic                  rs_full,
    input  logic                  rob2fetcher_jump_enable,
    input  logic [ADDR_WIDTH-1:0] rob2fetcher_jump_pc,
    output logic                  fetcher2icache_enable,
    output logic [ADDR_WIDTH-1:0] fetcher2icache_addr,
    input  logic                  icache2fetcher_valid,
    input  logic [INS_WIDTH-1:0]  icache2fetcher_ins,
    output logic                  fetch2decoder_enable,
    output logic [INS_WIDTH-1:0]  fetch2decoder_ins,
    output logic [ADDR_WIDTH-1:0] fetch2decoder_pc
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;

    logic                  q_push;
    logic                  q_flush;
    logic                  q_full;
    logic                  q_empty;
    logic [IQ_WIDTH:0]     q_count;
    logic [IQ_WIDTH:0]     count_after;
    iq_line_t              push_line;
    iq_line_t              head_line;

    assign q_flush   = rdy_in && rob2fetcher_jump_enable;
    assign q_push    = rdy_in && (state == FETCH_WAIT) && icache2fetcher_valid
                       && !rob2fetcher_jump_enable;
    assign push_line = '{pc: fetcher2icache_addr, ins: icache2fetcher_ins};

    assign fetch2decoder_enable = !q_empty && !rob_full && !rs_full && rdy_in
                                  && !rob2fetcher_jump_enable;
    assign fetch2decoder_ins    = q_empty ? '0 : head_line.ins;
    assign fetch2decoder_pc     = q_empty ? '0 : head_line.pc;

    // Occupancy once this cycle's response lands and any delivery leaves; the MSB means no slot left.
    assign count_after = q_count + (IQ_WIDTH+1)'(1) - (IQ_WIDTH+1)'(fetch2decoder_enable);

    fetch_queue #(
        .DEPTH_LOG2 (IQ_WIDTH),
        .WIDTH      (IQ_LINE_LENGTH)
    ) u_fetch_queue (
        .core_clk (clk_in),
        .arst_n   (rst_in),
        .flush    (q_flush),
        .push     (q_push),
        .push_dat (push_line),
        .pop      (fetch2decoder_enable),
        .head_dat (head_line),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Request FSM: jump redirects first; a live request is never abandoned, only marked stale.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state                 <= FETCH_IDLE;
            pc                    <= RESET_PC;
            fetcher2icache_enable <= 1'b0;
            fetcher2icache_addr   <= '0;
        end else if (rdy_in) begin
            if (rob2fetcher_jump_enable) begin
                pc <= {rob2fetcher_jump_pc[ADDR_WIDTH-1:2], 2'b00};
                if (state != FETCH_IDLE) begin
                    if (icache2fetcher_valid) begin
                        fetcher2icache_enable <= 1'b0;
                        state                 <= FETCH_IDLE;
                    end else begin
                        state <= FETCH_DROP;
                    end
                end
            end else begin
                case (state)
                    FETCH_IDLE: begin
                        if (!q_full) begin
                            fetcher2icache_enable <= 1'b1;
                            fetcher2icache_addr   <= pc;
                            state                 <= FETCH_WAIT;
                        end
                    end
                    FETCH_WAIT: begin
                        if (icache2fetcher_valid) begin
                            pc <= next_pc(fetcher2icache_addr);
                            if (!count_after[IQ_WIDTH]) begin
                                fetcher2icache_addr <= next_pc(fetcher2icache_addr);
                            end else begin
                                fetcher2icache_enable <= 1'b0;
                                state                 <= FETCH_IDLE;
                            end
                        end
                    end
                    FETCH_DROP: begin
                        if (icache2fetcher_valid) begin
                            fetcher2icache_enable <= 1'b0;
                            state                 <= FETCH_IDLE;
                        end
                    end
                    default: begin
                        fetcher2icache_enable <= 1'b0;
                        state                 <= FETCH_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: scripted icache responses plus an auto-responding icache model.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure is exercised through rob_full, rdy_in and jump stimulus.
module tb_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_full = 1'b0;
    logic        rs_full = 1'b0;
    logic        rob2fetcher_jump_enable = 1'b0;
    logic [31:0] rob2fetcher_jump_pc = '0;
    logic        fetcher2icache_enable;
    logic [31:0] fetcher2icache_addr;
    logic        icache2fetcher_valid = 1'b0;
    logic [31:0] icache2fetcher_ins = '0;
    logic        fetch2decoder_enable;
    logic [31:0] fetch2decoder_ins;
    logic [31:0] fetch2decoder_pc;

    int errors = 0;
    int checks = 0;

    fetcher dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .rdy_in                  (rdy_in),
        .rob_full                (rob_full),
        .rs_full                 (rs_full),
        .rob2fetcher_jump_enable (rob2fetcher_jump_enable),
        .rob2fetcher_jump_pc     (rob2fetcher_jump_pc),
        .fetcher2icache_enable   (fetcher2icache_enable),
        .fetcher2icache_addr     (fetcher2icache_addr),
        .icache2fetcher_valid    (icache2fetcher_valid),
        .icache2fetcher_ins      (icache2fetcher_ins),
        .fetch2decoder_enable    (fetch2decoder_enable),
        .fetch2decoder_ins       (fetch2decoder_ins),
        .fetch2decoder_pc        (fetch2decoder_pc)
    );

    always #5 clk_in = ~clk_in;

    // Instruction word the icache model returns for an address (0x13 at address 0).
    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    // Auto icache: respond lat cycles after seeing a request, one-cycle strobe.
    logic auto_icache = 1'b0;
    int   lat = 1;
    int   wait_cnt = 0;
    always @(posedge clk_in) begin
        #1;
        if (auto_icache) begin
            if (icache2fetcher_valid) begin
                icache2fetcher_valid = 1'b0;
                wait_cnt = 0;
            end else if (fetcher2icache_enable) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    icache2fetcher_valid = 1'b1;
                    icache2fetcher_ins   = ins_of(fetcher2icache_addr);
                end
            end
        end
    end

    // Monitor: logs new requests and decoder deliveries with their cycle numbers.
    int          cyc = 0;
    logic        req_open = 1'b0;
    logic [31:0] req_q[$];
    logic [31:0] dec_pc_q[$];
    logic [31:0] dec_ins_q[$];
    int          dec_cyc_q[$];
    always @(negedge clk_in) begin
        cyc++;
        if (!rst_in) begin
            req_open = 1'b0;
        end else begin
            if (fetcher2icache_enable && !req_open) begin
                req_q.push_back(fetcher2icache_addr);
                req_open = 1'b1;
            end
            if (icache2fetcher_valid) req_open = 1'b0;
            if (fetch2decoder_enable) begin
                dec_pc_q.push_back(fetch2decoder_pc);
                dec_ins_q.push_back(fetch2decoder_ins);
                dec_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        auto_icache = 1'b0;
        wait_cnt = 0;
        icache2fetcher_valid = 1'b0;
        icache2fetcher_ins = '0;
        rob2fetcher_jump_enable = 1'b0;
        rob2fetcher_jump_pc = '0;
        rob_full = 1'b0;
        rs_full = 1'b0;
        rdy_in = 1'b1;
        rst_in = 1'b0;
        repeat (2) tick();
        req_q.delete();
        dec_pc_q.delete();
        dec_ins_q.delete();
        dec_cyc_q.delete();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) tick();
        sample();
        checks++; if (fetcher2icache_enable !== 1'b0) begin errors++; $display("FAIL reset_req_en got %b want 0", fetcher2icache_enable); end
        checks++; if (fetcher2icache_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", fetcher2icache_addr); end
        checks++; if (fetch2decoder_enable !== 1'b0) begin errors++; $display("FAIL reset_dec_en got %b want 0", fetch2decoder_enable); end
        checks++; if (fetch2decoder_ins !== 32'h0) begin errors++; $display("FAIL reset_dec_ins got %h want 0", fetch2decoder_ins); end
        checks++; if (fetch2decoder_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got %h want 0", fetch2decoder_pc); end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1;
        auto_icache = 1'b1;
        repeat (24) tick();
        auto_icache = 1'b0;
        checks++;
        if (req_q.size() < 4) begin
            errors++; $display("FAIL stream_req_count got %0d want >=4", req_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (req_q[i] !== 32'(i * 4)) begin errors++; $display("FAIL stream_req%0d got %h want %h", i, req_q[i], 32'(i * 4)); end
            end
        end
        checks++;
        if (dec_pc_q.size() < 4) begin
            errors++; $display("FAIL stream_dec_count got %0d want >=4", dec_pc_q.size());
        end else begin
            for (int i = 0; i < dec_pc_q.size(); i++) begin
                checks++; if (dec_pc_q[i] !== 32'(i * 4)) begin errors++; $display("FAIL stream_dec_pc%0d got %h want %h", i, dec_pc_q[i], 32'(i * 4)); end
                checks++; if (dec_ins_q[i] !== ins_of(32'(i * 4))) begin errors++; $display("FAIL stream_dec_ins%0d got %h want %h", i, dec_ins_q[i], ins_of(32'(i * 4))); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rob_full = 1'b1;
        lat = 1;
        auto_icache = 1'b1;
        repeat (20) tick();
        sample();
        checks++; if (req_q.size() != 4) begin errors++; $display("FAIL bp_req_count got %0d want 4", req_q.size()); end
        checks++; if (fetcher2icache_enable !== 1'b0) begin errors++; $display("FAIL bp_req_en got %b want 0", fetcher2icache_enable); end
        checks++; if (dec_pc_q.size() != 0) begin errors++; $display("FAIL bp_dec_count got %0d want 0", dec_pc_q.size()); end
        rob_full = 1'b0;
        repeat (12) tick();
        auto_icache = 1'b0;
        checks++;
        if (dec_pc_q.size() < 4) begin
            errors++; $display("FAIL bp_release_count got %0d want >=4", dec_pc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (dec_pc_q[i] !== 32'(i * 4)) begin errors++; $display("FAIL bp_release_pc%0d got %h want %h", i, dec_pc_q[i], 32'(i * 4)); end
                checks++; if (dec_cyc_q[i] != dec_cyc_q[0] + i) begin errors++; $display("FAIL bp_release_cyc%0d got %0d want %0d", i, dec_cyc_q[i], dec_cyc_q[0] + i); end
            end
        end
        checks++;
        if (req_q.size() < 5) begin
            errors++; $display("FAIL bp_resume_count got %0d want >=5", req_q.size());
        end else if (req_q[4] !== 32'h10) begin
            errors++; $display("FAIL bp_resume_addr got %h want 00000010", req_q[4]);
        end
    endtask

    task automatic test_jump_drop();
        do_reset();
        tick();
        icache2fetcher_valid = 1'b1; icache2fetcher_ins = ins_of(32'h0);
        tick();
        icache2fetcher_ins = ins_of(32'h4);
        sample();
        checks++; if (fetch2decoder_enable !== 1'b1 || fetch2decoder_pc !== 32'h0) begin errors++; $display("FAIL drop_pre_dec got en=%b pc=%h want en=1 pc=0", fetch2decoder_enable, fetch2decoder_pc); end
        tick();
        icache2fetcher_valid = 1'b0;
        rob2fetcher_jump_enable = 1'b1; rob2fetcher_jump_pc = 32'h103;
        sample();
        checks++; if (fetch2decoder_enable !== 1'b0) begin errors++; $display("FAIL drop_jump_dec_en got %b want 0", fetch2decoder_enable); end
        checks++; if (fetcher2icache_addr !== 32'h8) begin errors++; $display("FAIL drop_jump_addr got %h want 8", fetcher2icache_addr); end
        tick();
        rob2fetcher_jump_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                icache2fetcher_valid = 1'b1; icache2fetcher_ins = 32'hDEADBEEF;
            end
            sample();
            checks++; if (fetcher2icache_enable !== 1'b1 || fetcher2icache_addr !== 32'h8) begin errors++; $display("FAIL drop_hold%0d got en=%b addr=%h want en=1 addr=8", i, fetcher2icache_enable, fetcher2icache_addr); end
            checks++; if (fetch2decoder_enable !== 1'b0) begin errors++; $display("FAIL drop_empty%0d got %b want 0", i, fetch2decoder_enable); end
            tick();
        end
        icache2fetcher_valid = 1'b0;
        sample();
        checks++; if (fetcher2icache_enable !== 1'b0 || fetch2decoder_enable !== 1'b0) begin errors++; $display("FAIL drop_discard got req_en=%b dec_en=%b want 0 0", fetcher2icache_enable, fetch2decoder_enable); end
        tick();
        sample();
        checks++; if (fetcher2icache_enable !== 1'b1 || fetcher2icache_addr !== 32'h100) begin errors++; $display("FAIL drop_redirect got en=%b addr=%h want en=1 addr=100", fetcher2icache_enable, fetcher2icache_addr); end
        icache2fetcher_valid = 1'b1; icache2fetcher_ins = ins_of(32'h100);
        tick();
        icache2fetcher_valid = 1'b0;
        sample();
        checks++; if (fetch2decoder_enable !== 1'b1 || fetch2decoder_pc !== 32'h100 || fetch2decoder_ins !== ins_of(32'h100)) begin errors++; $display("FAIL drop_first_dec got en=%b pc=%h ins=%h want en=1 pc=100 ins=%h", fetch2decoder_enable, fetch2decoder_pc, fetch2decoder_ins, ins_of(32'h100)); end
    endtask

    task automatic test_jump_valid();
        do_reset();
        tick();
        icache2fetcher_valid = 1'b1; icache2fetcher_ins = ins_of(32'h0);
        tick();
        icache2fetcher_ins = ins_of(32'h4);
        rob2fetcher_jump_enable = 1'b1; rob2fetcher_jump_pc = 32'h200;
        sample();
        checks++; if (fetch2decoder_enable !== 1'b0) begin errors++; $display("FAIL jv_dec_en got %b want 0", fetch2decoder_enable); end
        checks++; if (fetcher2icache_addr !== 32'h4) begin errors++; $display("FAIL jv_addr got %h want 4", fetcher2icache_addr); end
        tick();
        icache2fetcher_valid = 1'b0; rob2fetcher_jump_enable = 1'b0;
        sample();
        checks++; if (fetcher2icache_enable !== 1'b0 || fetch2decoder_enable !== 1'b0) begin errors++; $display("FAIL jv_after got req_en=%b dec_en=%b want 0 0", fetcher2icache_enable, fetch2decoder_enable); end
        tick();
        sample();
        checks++; if (fetcher2icache_enable !== 1'b1 || fetcher2icache_addr !== 32'h200) begin errors++; $display("FAIL jv_redirect got en=%b addr=%h want en=1 addr=200", fetcher2icache_enable, fetcher2icache_addr); end
        icache2fetcher_valid = 1'b1; icache2fetcher_ins = ins_of(32'h200);
        tick();
        icache2fetcher_valid = 1'b0;
        sample();
        checks++; if (fetch2decoder_enable !== 1'b1 || fetch2decoder_pc !== 32'h200 || fetch2decoder_ins !== ins_of(32'h200)) begin errors++; $display("FAIL jv_first_dec got en=%b pc=%h ins=%h want en=1 pc=200 ins=%h", fetch2decoder_enable, fetch2decoder_pc, fetch2decoder_ins, ins_of(32'h200)); end
    endtask

    task automatic test_pause();
        do_reset();
        tick();
        icache2fetcher_valid = 1'b1; icache2fetcher_ins = ins_of(32'h0);
        tick();
        icache2fetcher_valid = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            checks++; if (fetcher2icache_enable !== 1'b1 || fetcher2icache_addr !== 32'h4) begin errors++; $display("FAIL pause_req%0d got en=%b addr=%h want en=1 addr=4", i, fetcher2icache_enable, fetcher2icache_addr); end
            checks++; if (fetch2decoder_enable !== 1'b0) begin errors++; $display("FAIL pause_dec%0d got %b want 0", i, fetch2decoder_enable); end
            tick();
        end
        rdy_in = 1'b1;
        icache2fetcher_valid = 1'b1; icache2fetcher_ins = ins_of(32'h4);
        sample();
        checks++; if (fetch2decoder_enable !== 1'b1 || fetch2decoder_pc !== 32'h0 || fetch2decoder_ins !== 32'h13) begin errors++; $display("FAIL pause_resume_dec got en=%b pc=%h ins=%h want en=1 pc=0 ins=13", fetch2decoder_enable, fetch2decoder_pc, fetch2decoder_ins); end
        tick();
        icache2fetcher_valid = 1'b0;
        sample();
        checks++; if (fetch2decoder_enable !== 1'b1 || fetch2decoder_pc !== 32'h4) begin errors++; $display("FAIL pause_next_dec got en=%b pc=%h want en=1 pc=4", fetch2decoder_enable, fetch2decoder_pc); end
        checks++; if (fetcher2icache_addr !== 32'h8) begin errors++; $display("FAIL pause_next_addr got %h want 8", fetcher2icache_addr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        rob_full = 1'b1;
        tick();
        icache2fetcher_valid = 1'b1; icache2fetcher_ins = ins_of(32'h0);
        tick();
        icache2fetcher_ins = ins_of(32'h4);
        tick();
        icache2fetcher_ins = ins_of(32'h8);
        tick();
        icache2fetcher_valid = 1'b0;
        sample();
        checks++; if (fetcher2icache_enable !== 1'b1 || fetcher2icache_addr !== 32'hC) begin errors++; $display("FAIL ar_pre_req got en=%b addr=%h want en=1 addr=c", fetcher2icache_enable, fetcher2icache_addr); end
        checks++; if (fetch2decoder_ins !== 32'h13) begin errors++; $display("FAIL ar_pre_head got %h want 13", fetch2decoder_ins); end
        #2;
        rst_in = 1'b0;
        #1;
        checks++; if (fetcher2icache_enable !== 1'b0 || fetcher2icache_addr !== 32'h0) begin errors++; $display("FAIL ar_req got en=%b addr=%h want 0 0", fetcher2icache_enable, fetcher2icache_addr); end
        checks++; if (fetch2decoder_enable !== 1'b0 || fetch2decoder_ins !== 32'h0 || fetch2decoder_pc !== 32'h0) begin errors++; $display("FAIL ar_dec got en=%b ins=%h pc=%h want 0 0 0", fetch2decoder_enable, fetch2decoder_ins, fetch2decoder_pc); end
        tick();
        rst_in = 1'b1;
        rob_full = 1'b0;
        tick();
        sample();
        checks++; if (fetcher2icache_enable !== 1'b1 || fetcher2icache_addr !== 32'h0) begin errors++; $display("FAIL ar_first_req got en=%b addr=%h want en=1 addr=0", fetcher2icache_enable, fetcher2icache_addr); end
        checks++; if (fetch2decoder_enable !== 1'b0) begin errors++; $display("FAIL ar_dec_after got %b want 0", fetch2decoder_enable); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_drop();
        test_jump_valid();
        test_pause();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
